worker_cpu_cpu_mult_combine: RTL and testbench



---
 rtl/worker_cpu_mul_pkg.sv | 27 ++
 rtl/worker_cpu_pipe_stage.sv | 55 +++++
 rtl/worker_cpu_cpu_mult_combine.sv | 131 +++++++++++++
 tb/tb_worker_cpu_cpu_mult_combine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/worker_cpu_mul_pkg.sv
// Shared types and constants for the MUL result combiner.
// Optional feature macro: WORKER_MUL_COMBINE_HI_EN. When it is defined, the stage records also
// carry the hi*hi partial product and the upper result word.
package worker_cpu_mul_pkg;

    localparam int unsigned MUL_W  = 32;
    localparam int unsigned HALF_W = 16;

    // S1 record. The destination tag travels beside this struct in the stage slice because its
    // width is a module parameter.
    typedef struct packed {
        logic [MUL_W-1:0] p1;
        logic [MUL_W:0]   mid;   // p2 + p3 with its carry
`ifdef WORKER_MUL_COMBINE_HI_EN
        logic [MUL_W-1:0] p4;
`endif
    } mul_s1_t;

    // S2 record: the folded result words.
    typedef struct packed {
        logic [MUL_W-1:0] lo;
`ifdef WORKER_MUL_COMBINE_HI_EN
        logic [MUL_W-1:0] hi;
`endif
    } mul_s2_t;

endpackage

// File: rtl/worker_cpu_pipe_stage.sv
// Generic valid/ready register slice with a synchronous flush.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   flush                 drops the held entry at the next edge and blocks a load
//   in_valid/in_ready     upstream handshake; in_ready = ~valid | out_ready
//   in_data               payload captured on an accepted load
//   out_valid/out_ready   downstream handshake
//   out_data              registered payload
module worker_cpu_pipe_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             adv;
    logic             load;

    always_comb begin
        adv     = ~valid_q | out_ready;
        load    = adv & in_valid & ~flush;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = in_valid;
        end
        // Data only moves on a real load so an idle or stalled slice does not toggle.
        data_d = load ? in_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/worker_cpu_cpu_mult_combine.sv
// Folds the registered 16x16 partial products of a 32x32 multiply into the MUL result.
// Two-stage valid/ready pipeline: S1 captures p1 and mid = p2 + p3, S2 holds the result.
// Optional feature macro: WORKER_MUL_COMBINE_HI_EN adds in_p4 and out_result_hi, giving the
// full unsigned 64-bit product.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   flush                   kills every in-flight op; blocks acceptance this cycle
//   in_valid/in_ready       partial-product handshake
//   in_p1/in_p2/in_p3       lo*lo, lo1*hi2, hi1*lo2
//   in_p4                   hi*hi (feature only)
//   in_tag                  destination tag
//   out_valid/out_ready     result handshake
//   out_result              low 32 bits of the product
//   out_result_hi           high 32 bits of the product (feature only)
//   out_tag                 tag of out_result
//   busy                    any stage holds an op
module worker_cpu_cpu_mult_combine
    import worker_cpu_mul_pkg::*;
#(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_p1,
    input  logic [DATA_W-1:0] in_p2,
    input  logic [DATA_W-1:0] in_p3,
`ifdef WORKER_MUL_COMBINE_HI_EN
    input  logic [DATA_W-1:0] in_p4,
    output logic [DATA_W-1:0] out_result_hi,
`endif
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("worker_cpu_cpu_mult_combine: DATA_W must be 32");
    end

    localparam int unsigned S1W = TAG_W + $bits(mul_s1_t);
    localparam int unsigned S2W = TAG_W + $bits(mul_s2_t);

    mul_s1_t          s1_in, s1_q;
    mul_s2_t          s2_in, s2_q;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [S1W-1:0]   s1_data;
    logic [S2W-1:0]   s2_data;
    logic             s1_valid, s1_in_ready;
    logic             s2_valid, s2_in_ready;

    // S1 capture: the two cross products share the same 2^16 weight, so add them first.
    always_comb begin
        s1_in     = '0;
        s1_in.p1  = in_p1;
        s1_in.mid = {1'b0, in_p2} + {1'b0, in_p3};
`ifdef WORKER_MUL_COMBINE_HI_EN
        s1_in.p4  = in_p4;
`endif
    end

    worker_cpu_pipe_stage #(
        .Width (S1W)
    ) u_stage1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s1_in_ready),
        .in_data   ({in_tag, s1_in}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign {s1_tag, s1_q} = s1_data;

`ifdef WORKER_MUL_COMBINE_HI_EN
    logic [MUL_W:0] lo_sum;

    always_comb begin
        s2_in    = '0;
        lo_sum   = {1'b0, s1_q.p1} + {1'b0, s1_q.mid[HALF_W-1:0], {HALF_W{1'b0}}};
        s2_in.lo = lo_sum[MUL_W-1:0];
        // Upper word: hi*hi, the upper 17 bits of mid, and the carry out of the low word.
        s2_in.hi = s1_q.p4 + {{(MUL_W-HALF_W-1){1'b0}}, s1_q.mid[MUL_W:HALF_W]}
                 + {{(MUL_W-1){1'b0}}, lo_sum[MUL_W]};
    end
`else
    logic unused_mid_hi;

    always_comb begin
        s2_in    = '0;
        s2_in.lo = s1_q.p1 + {s1_q.mid[HALF_W-1:0], {HALF_W{1'b0}}};
    end

    assign unused_mid_hi = ^s1_q.mid[MUL_W:HALF_W];
`endif

    worker_cpu_pipe_stage #(
        .Width (S2W)
    ) u_stage2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({s1_tag, s2_in}),
        .out_valid (s2_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {s2_tag, s2_q} = s2_data;

    assign in_ready   = s1_in_ready & ~flush;
    assign out_valid  = s2_valid;
    assign out_result = s2_q.lo;
    assign out_tag    = s2_tag;
    assign busy       = s1_valid | s2_valid;
`ifdef WORKER_MUL_COMBINE_HI_EN
    assign out_result_hi = s2_q.hi;
`endif

endmodule

// File: tb/tb_worker_cpu_cpu_mult_combine.sv
// Bench for worker_cpu_cpu_mult_combine: queue-based reference of in-flight ops checked
// against the DUT every cycle, plus directed literal expectations.
module tb_worker_cpu_cpu_mult_combine;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_p1 = '0, in_p2 = '0, in_p3 = '0, in_p4 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [31:0]      out_result_hi;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    worker_cpu_cpu_mult_combine #(
        .TAG_W  (TAG_W),
        .DATA_W (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_p1         (in_p1),
        .in_p2         (in_p2),
        .in_p3         (in_p3),
`ifdef WORKER_MUL_COMBINE_HI_EN
        .in_p4         (in_p4),
        .out_result_hi (out_result_hi),
`endif
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_tag       (out_tag),
        .busy          (busy)
    );

`ifndef WORKER_MUL_COMBINE_HI_EN
    assign out_result_hi = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      lo;
        logic [31:0]      hi;
        logic [TAG_W-1:0] tag;
        int               entry;
    } exp_t;

    exp_t        q[$];
    int          edge_cnt = 0;
    bit          armed = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cur_lo = '0, cur_hi = '0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    // Directed op from raw partial products; expectation from the weighted 64-bit sum.
    task automatic set_op(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                          input logic [31:0] p4, input logic [TAG_W-1:0] tag);
        logic [63:0] full;
        full   = 64'(p1) + ((64'(p2) + 64'(p3)) << 16) + (64'(p4) << 32);
        in_p1  = p1;
        in_p2  = p2;
        in_p3  = p3;
        in_p4  = p4;
        in_tag = tag;
        cur_lo = full[31:0];
        cur_hi = full[63:32];
    endtask

    // Random operand pair; expectation is the plain product A*B.
    task automatic set_rand_op();
        logic [31:0] a, b;
        logic [63:0] prod;
        a      = $urandom;
        b      = $urandom;
        prod   = 64'(a) * 64'(b);
        in_p1  = {16'h0, a[15:0]} * {16'h0, b[15:0]};
        in_p2  = {16'h0, a[15:0]} * {16'h0, b[31:16]};
        in_p3  = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        in_p4  = {16'h0, a[31:16]} * {16'h0, b[31:16]};
        in_tag = TAG_W'($urandom);
        cur_lo = prod[31:0];
        cur_hi = prod[63:32];
    endtask

    // Reference: an ordered list of accepted ops. The oldest op is presented once it has
    // sat through one further edge after acceptance; at most two ops can be held.
    always @(negedge clk) begin
        logic ev, er;
        exp_t e;
        ev = (q.size() > 0) && ((edge_cnt - q[0].entry) >= 1);
        er = !flush && ((q.size() < 2) || out_ready);
        if (armed) begin
            check("out_valid", 64'(out_valid), 64'(ev));
            check("in_ready", 64'(in_ready), 64'(er));
            check("busy", 64'(busy), 64'(q.size() > 0));
            if (ev) begin
                check("out_result", 64'(out_result), 64'(q[0].lo));
                check("out_tag", 64'(out_tag), 64'(q[0].tag));
`ifdef WORKER_MUL_COMBINE_HI_EN
                check("out_result_hi", 64'(out_result_hi), 64'(q[0].hi));
`endif
            end
        end
        // Model the coming edge.
        if (!reset_n) begin
            q.delete();
            armed = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (ev && out_ready) void'(q.pop_front());
            if (in_valid && er) begin
                e.lo    = cur_lo;
                e.hi    = cur_hi;
                e.tag   = in_tag;
                e.entry = edge_cnt + 1;
                q.push_back(e);
            end
        end
        edge_cnt++;
    end

    initial begin
        int acc;
        int sent;
        int cyc;
        bit xfer;

        // 1 reset with in_valid held high
        set_op(32'd1, 32'd2, 32'd3, 32'd4, 5'd9);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // 2 basic
        @(posedge clk);
        #1;
        set_op(32'd8, 32'd10, 32'd12, 32'd15, 5'd3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_result", 64'(out_result), 64'h0016_0008);
`ifdef WORKER_MUL_COMBINE_HI_EN
        check("basic_result_hi", 64'(out_result_hi), 64'h0000_000F);
`endif

        // 3 carry out of the low word
        @(posedge clk);
        #1;
        set_op(32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 5'd7);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("carry_result", 64'(out_result), 64'h0000_0001);
`ifdef WORKER_MUL_COMBINE_HI_EN
        check("carry_result_hi", 64'(out_result_hi), 64'hFFFF_FFFE);
`endif

        // 4 backpressure: four ops, out_ready low for five cycles
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        acc = 0;
        set_op(32'h100, 32'h11, 32'h22, 32'h3, 5'd1);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            xfer = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (xfer) begin
                acc++;
                set_op(32'h100 + 32'(acc), 32'h11 * 32'(acc + 1), 32'h22, 32'(acc), 5'(acc + 1));
            end
        end
        @(negedge clk);
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cyc = 0;
        while (acc < 4 && cyc < 20) begin
            @(negedge clk);
            xfer = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (xfer) begin
                acc++;
                set_op(32'h100 + 32'(acc), 32'h11 * 32'(acc + 1), 32'h22, 32'(acc), 5'(acc + 1));
            end
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(acc), 64'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_drained", 64'(q.size()), 64'd0);

        // 5 flush with a full pipeline and a new op offered
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        set_op(32'hAAAA, 32'h5, 32'h6, 32'h7, 5'd20);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        set_op(32'hBBBB, 32'h8, 32'h9, 32'hA, 5'd21);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        check("flush_busy_before", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("flush_no_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        set_op(32'h1234, 32'h10, 32'h20, 32'h30, 5'd22);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_result", 64'(out_result), 64'h0030_1234);

        // 6 random streaming, out_ready ~70%
        @(posedge clk);
        #1;
        sent = 0;
        cyc  = 0;
        xfer = 1'b0;
        while (sent < 100 && cyc < 2000) begin
            if (xfer) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid && $urandom_range(0, 9) < 8) begin
                set_rand_op();
                in_valid = 1'b1;
            end
            @(negedge clk);
            xfer = in_valid && in_ready;
            if (xfer) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", 64'(sent), 64'd100);
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("rand_drained", 64'(q.size()), 64'd0);
        check("rand_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
